// File: rtl/fp_vector_packer.sv
// Stream-to-vector packer: groups NUM_INPUTS consecutive FP elements into one
// zero-padded vector and strobes it for a single cycle into the adder tree.
module fp_vector_packer #(
  parameter  int unsigned WIDTH      = 32,
  parameter  int unsigned NUM_INPUTS = 7,
  localparam int unsigned CNT_W      = $clog2(NUM_INPUTS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic [NUM_INPUTS*WIDTH-1:0] out_data,
  output logic                        out_valid,
  output logic                        out_last,
  output logic [CNT_W-1:0]            out_count
);

  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_INPUTS - 1);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_EMIT    = 1'b1
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic                          w_close;
  logic [CNT_W-1:0]              r_cnt;
  logic [WIDTH-1:0]              r_buf [NUM_INPUTS];
  logic [NUM_INPUTS*WIDTH-1:0]   w_vec;
  logic [NUM_INPUTS*WIDTH-1:0]   r_out_data;
  logic                          r_out_last;
  logic [CNT_W-1:0]              r_out_count;

  // EMIT is the strobe cycle; it overlaps collection of the next vector.
  always_comb begin
    w_close     = 1'b0;
    w_state_nxt = r_state;
    if (in_valid && ((r_cnt == LAST_LANE) || in_last)) begin
      w_close = 1'b1;
    end
    w_state_nxt = w_close ? S_EMIT : S_COLLECT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Lanes above the closing element are forced to zero, so stale buffer
  // contents from an earlier, longer vector can never leak out.
  always_comb begin
    w_vec = '0;
    for (int j = 0; j < NUM_INPUTS; j++) begin
      if (CNT_W'(j) < r_cnt) begin
        w_vec[j*WIDTH +: WIDTH] = r_buf[j];
      end else if (CNT_W'(j) == r_cnt) begin
        w_vec[j*WIDTH +: WIDTH] = in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      for (int j = 0; j < NUM_INPUTS; j++) begin
        r_buf[j] <= '0;
      end
    end else if (in_valid) begin
      if (w_close) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= CNT_W'(r_cnt + CNT_W'(1));
        for (int j = 0; j < NUM_INPUTS; j++) begin
          if (CNT_W'(j) == r_cnt) begin
            r_buf[j] <= in_data;
          end
        end
      end
    end
  end

  // Output payload is loaded only on a closing element and held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_count <= '0;
    end else if (w_close) begin
      r_out_data  <= w_vec;
      r_out_last  <= in_last;
      r_out_count <= CNT_W'(r_cnt + CNT_W'(1));
    end
  end

  assign out_valid = (r_state == S_EMIT);
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_fp_vector_packer.sv
// Directed self-checking bench for fp_vector_packer (WIDTH=32, NUM_INPUTS=7).
module tb_fp_vector_packer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned N     = 7;
  localparam int unsigned CW    = $clog2(N + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [WIDTH-1:0]   in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic [N*WIDTH-1:0] out_data;
  logic               out_valid;
  logic               out_last;
  logic [CW-1:0]      out_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] fvals [14];

  fp_vector_packer #(.WIDTH(WIDTH), .NUM_INPUTS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  function automatic logic [N*WIDTH-1:0] exp_vec(input int start, input int n);
    logic [N*WIDTH-1:0] v;
    v = '0;
    for (int j = 0; j < n; j++) v[j*WIDTH +: WIDTH] = fvals[start + j];
    return v;
  endfunction

  // One clock: drive inputs, then sample 1ns after the rising edge.
  task automatic step(input logic v, input logic [31:0] d, input logic l);
    in_valid = v; in_data = d; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
  endtask

  task automatic test_reset;
    #2;
    n_tests++;
    if ({out_valid, out_last, out_count, out_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: got v=%b l=%b c=%0d d=%h, need all zero", out_valid, out_last, out_count, out_data);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_full;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, fvals[i], 1'b0);
      n_tests++;
      if (out_valid !== (i == 6)) begin
        n_fail++;
        $display("FAIL full_strobe_%0d: got %b need %b", i, out_valid, (i == 6));
      end
    end
    n_tests++;
    if (out_data !== exp_vec(0, 7) || out_count !== CW'(7) || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL full_payload: got d=%h c=%0d l=%b need d=%h c=7 l=0", out_data, out_count, out_last, exp_vec(0, 7));
    end
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== exp_vec(0, 7) || out_count !== CW'(7)) begin
      n_fail++;
      $display("FAIL full_hold: got v=%b d=%h c=%0d need v=0 d=%h c=7", out_valid, out_data, out_count, exp_vec(0, 7));
    end
  endtask

  task automatic test_short;
    step(1'b1, fvals[0], 1'b0);
    step(1'b1, fvals[1], 1'b0);
    step(1'b1, fvals[2], 1'b1);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== exp_vec(0, 3) || out_count !== CW'(3) || out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL short3: got v=%b d=%h c=%0d l=%b need v=1 d=%h c=3 l=1", out_valid, out_data, out_count, out_last, exp_vec(0, 3));
    end
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, fvals[9], 1'b1);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== exp_vec(9, 1) || out_count !== CW'(1) || out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL short1_no_stale: got v=%b d=%h c=%0d l=%b need v=1 d=%h c=1 l=1", out_valid, out_data, out_count, out_last, exp_vec(9, 1));
    end
    step(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_async_reset;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({out_valid, out_last, out_count, out_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got v=%b l=%b c=%0d d=%h, need all zero", out_valid, out_last, out_count, out_data);
    end
    step(1'b1, fvals[4], 1'b1);
    n_tests++;
    if ({out_valid, out_last, out_count, out_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_held: got v=%b l=%b c=%0d d=%h, need all zero", out_valid, out_last, out_count, out_data);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_continuous;
    int strobes[$];
    logic [N*WIDTH-1:0] d0;
    logic l0;
    d0 = '0; l0 = 1'bx;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, fvals[i], (i == 13));
      if (out_valid === 1'b1) begin
        strobes.push_back(i);
        if (strobes.size() == 1) begin d0 = out_data; l0 = out_last; end
      end
    end
    n_tests++;
    if (strobes.size() != 2 || strobes[0] != 6 || strobes[1] != 13) begin
      n_fail++;
      $display("FAIL cont_strobe_timing: got %0d strobes, need 2 at steps 6 and 13", strobes.size());
    end
    n_tests++;
    if (d0 !== exp_vec(0, 7) || l0 !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_first: got d=%h l=%b need d=%h l=0", d0, l0, exp_vec(0, 7));
    end
    n_tests++;
    if (out_data !== exp_vec(7, 7) || out_last !== 1'b1 || out_count !== CW'(7)) begin
      n_fail++;
      $display("FAIL cont_second: got d=%h c=%0d l=%b need d=%h c=7 l=1", out_data, out_count, out_last, exp_vec(7, 7));
    end
  endtask

  task automatic test_back_to_back;
    int ok;
    ok = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, fvals[10 + i], 1'b1);
      if (out_valid === 1'b1 && out_data === exp_vec(10 + i, 1) && out_count === CW'(1) && out_last === 1'b1) ok++;
    end
    n_tests++;
    if (ok != 3) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d good strobes need 3", ok);
    end
    step(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_gapped;
    int gaps[6] = '{2, 0, 3, 1, 2, 3};
    int nstrobe;
    nstrobe = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, fvals[7 + i], 1'b0);
      if (out_valid === 1'b1) nstrobe++;
      if (i < 6) begin
        for (int g = 0; g < gaps[i]; g++) begin
          step(1'b0, 32'hDEADBEEF, 1'b1);
          if (out_valid === 1'b1) nstrobe++;
        end
      end
    end
    n_tests++;
    if (nstrobe != 1 || out_valid !== 1'b1 || out_count !== CW'(7) || out_last !== 1'b0 || out_data !== exp_vec(7, 7)) begin
      n_fail++;
      $display("FAIL gapped: got %0d strobes v=%b c=%0d l=%b d=%h need 1 strobe on last c=7 l=0 d=%h",
               nstrobe, out_valid, out_count, out_last, out_data, exp_vec(7, 7));
    end
    step(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid;
    int nstrobe;
    nstrobe = 0;
    for (int i = 0; i < 4; i++) step(1'b1, fvals[10 + i], 1'b0);
    rst = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, fvals[i], 1'b0);
      if (out_valid === 1'b1) nstrobe++;
    end
    step(1'b0, 32'h0, 1'b0);
    if (out_valid === 1'b1) nstrobe++;
    n_tests++;
    if (nstrobe != 1 || out_data !== exp_vec(0, 7) || out_count !== CW'(7) || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got %0d strobes d=%h c=%0d l=%b need 1 strobe d=%h c=7 l=0",
               nstrobe, out_data, out_count, out_last, exp_vec(0, 7));
    end
  endtask

  initial begin
    fvals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
              32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
              32'h41500000, 32'h41600000};
    test_reset();
    test_full();
    test_short();
    test_async_reset();
    test_continuous();
    test_back_to_back();
    test_gapped();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
